// File: rtl/johnson_pkg.sv
// Shared types and constants for Johnson counter consumers.
package johnson_pkg;

    // Default number of Johnson stages; the ring has twice this many codes.
    localparam int JC_WIDTH  = 4;
    localparam int PHASES    = 2 * JC_WIDTH;
    localparam int IDX_W     = $clog2(PHASES);

    // Advance counter width; large enough for lock thresholds up to 15.
    localparam int ADV_CNT_W = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACKING = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        ADV  = 2'd1,
        JUMP = 2'd2,
        BAD  = 2'd3
    } trans_e;

    // Number of legal codes on a Johnson ring of the given stage count.
    function automatic int phase_count(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder: code -> legal flag and phase index.
// Phase k < WIDTH has the k top bits set; phase k >= WIDTH has the low
// 2*WIDTH-k bits set. Any other pattern is illegal.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = JC_WIDTH,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] jc_in,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    localparam int NPH = 2 * WIDTH;

    logic [WIDTH-1:0] pat;

    // Compare the input against every legal ring pattern.
    always_comb begin
        legal = 1'b0;
        idx   = '0;
        pat   = '0;
        for (int k = 0; k < NPH; k++) begin
            if (k < WIDTH) begin
                pat = ~({WIDTH{1'b1}} >> k);
            end else begin
                pat = {WIDTH{1'b1}} >> (k - WIDTH);
            end
            if (!legal && (jc_in == pat)) begin
                legal = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/johnson_sequence_monitor.sv
// Johnson sequence monitor: decodes the counter code, checks the sequence,
// locks onto a legal advancing ring, counts revolutions and flags errors.
//
// state    | meaning
// UNLOCKED | no trusted reference; first legal code starts tracking
// TRACKING | counting consecutive +1 advances toward lock
// LOCKED   | ring confirmed; jumps or bad codes raise seq_err
module johnson_sequence_monitor
    import johnson_pkg::*;
#(
    parameter int WIDTH      = JC_WIDTH,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              jc_in,
    input  logic                          err_clr,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          code_valid,
    output logic                          locked,
    output logic                          seq_err,
    output logic [CNT_W-1:0]              rev_count,
    output logic                          rev_wrap
);

    localparam int NPH = phase_count(WIDTH);
    localparam int IW  = $clog2(NPH);

    localparam logic [IW-1:0]        LAST_IDX = IW'(NPH - 1);
    localparam logic [ADV_CNT_W-1:0] LOCK_TGT = ADV_CNT_W'(LOCK_COUNT);
    localparam logic [NPH-1:0]       ONE_HOT0 = NPH'(1);

    logic                 dec_legal;
    logic [IW-1:0]        dec_idx;

    state_e               state_q,   state_d;
    logic [ADV_CNT_W-1:0] adv_cnt_q, adv_cnt_d;
    logic [IW-1:0]        idx_q,     idx_d;
    logic [NPH-1:0]       onehot_q,  onehot_d;
    logic                 valid_q,   valid_d;
    logic                 locked_q,  locked_d;
    logic                 err_q,     err_d;
    logic [CNT_W-1:0]     rev_q,     rev_d;
    logic                 wrap_q,    wrap_d;

    trans_e               tcls;
    logic [IW-1:0]        adv_idx;
    logic [ADV_CNT_W-1:0] adv_inc;
    logic                 err_set;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IW)
    ) u_decode (
        .jc_in (jc_in),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // Classify the sample against the previous legal index (idx_q).
    always_comb begin
        adv_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        tcls    = JUMP;
        if (!dec_legal) begin
            tcls = BAD;
        end else if (dec_idx == idx_q) begin
            tcls = HOLD;
        end else if (dec_idx == adv_idx) begin
            tcls = ADV;
        end
    end

    // Next-state for the sequencing FSM, counters and output registers.
    always_comb begin
        state_d   = state_q;
        adv_cnt_d = adv_cnt_q;
        idx_d     = idx_q;
        onehot_d  = onehot_q;
        valid_d   = valid_q;
        rev_d     = rev_q;
        wrap_d    = 1'b0;
        err_set   = 1'b0;
        adv_inc   = adv_cnt_q + ADV_CNT_W'(1);

        if (en) begin
            if (tcls == BAD) begin
                onehot_d = '0;
                valid_d  = 1'b0;
            end else begin
                idx_d    = dec_idx;
                onehot_d = ONE_HOT0 << dec_idx;
                valid_d  = 1'b1;
            end

            unique case (state_q)
                UNLOCKED: begin
                    if (tcls != BAD) begin
                        state_d   = TRACKING;
                        adv_cnt_d = '0;
                    end
                end
                TRACKING: begin
                    case (tcls)
                        ADV: begin
                            adv_cnt_d = adv_inc;
                            if (adv_inc == LOCK_TGT) begin
                                state_d = LOCKED;
                            end
                        end
                        JUMP:    adv_cnt_d = '0;
                        BAD:     state_d   = UNLOCKED;
                        default: ;
                    endcase
                end
                LOCKED: begin
                    case (tcls)
                        ADV: begin
                            // Only the 7->0 style step completes a revolution.
                            if (idx_q == LAST_IDX) begin
                                rev_d  = rev_q + CNT_W'(1);
                                wrap_d = &rev_q;
                            end
                        end
                        JUMP, BAD: begin
                            state_d = UNLOCKED;
                            err_set = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_d = UNLOCKED;
            endcase
        end

        // A new error beats a simultaneous clear; clear works regardless of en.
        err_d    = err_set | (err_q & ~err_clr);
        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            adv_cnt_q <= '0;
            idx_q     <= '0;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            rev_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adv_cnt_q <= adv_cnt_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            rev_q     <= rev_d;
            wrap_q    <= wrap_d;
        end
    end

    assign phase_onehot = onehot_q;
    assign phase_idx    = idx_q;
    assign code_valid   = valid_q;
    assign locked       = locked_q;
    assign seq_err      = err_q;
    assign rev_count    = rev_q;
    assign rev_wrap     = wrap_q;

endmodule
